// File: rtl/serial_word_receiver.sv
// Serial receiver: 7 data bits LSB first, optional odd parity (SERIAL_PARITY_EN),
// one stop bit; four accepted characters are packed into a 28-bit word.
module serial_word_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial,
    output logic [27:0] palavra,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_frame,
    output logic        erro_timeout,
    output logic [1:0]  contagem
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t         state_reg;
    logic           sync1_reg, sync2_reg, line_prev_reg;
    logic [CW-1:0]  sample_cnt_reg;
    logic [2:0]     bit_cnt_reg;
    logic [6:0]     shift_reg;
    logic [TW-1:0]  timeout_cnt_reg;
    logic [27:0]    asm_reg;
    logic [27:0]    asm_next;
    logic [27:0]    palavra_reg;
    logic [1:0]     contagem_reg;
    logic           pronto_reg, erro_frame_reg, erro_timeout_reg;
    logic           start_edge, sample_tick, parity_good;

    assign start_edge  = line_prev_reg & ~sync2_reg;
    assign sample_tick = (sample_cnt_reg == FULL_LAST);

`ifdef SERIAL_PARITY_EN
    logic parity_ok_reg;
    logic erro_paridade_reg;
    assign parity_good   = parity_ok_reg;
    assign erro_paridade = erro_paridade_reg;
`else
    assign parity_good   = 1'b1;
    assign erro_paridade = 1'b0;
`endif

    // Slot k (first character at the top) takes the freshly received character.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign asm_next[27-7*gi -: 7] = (contagem_reg == 2'(gi)) ? shift_reg
                                                                  : asm_reg[27-7*gi -: 7];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            sync1_reg        <= 1'b1;
            sync2_reg        <= 1'b1;
            line_prev_reg    <= 1'b1;
            sample_cnt_reg   <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            timeout_cnt_reg  <= '0;
            asm_reg          <= '0;
            palavra_reg      <= '0;
            contagem_reg     <= '0;
            pronto_reg       <= 1'b0;
            erro_frame_reg   <= 1'b0;
            erro_timeout_reg <= 1'b0;
`ifdef SERIAL_PARITY_EN
            parity_ok_reg     <= 1'b0;
            erro_paridade_reg <= 1'b0;
`endif
        end else begin
            sync1_reg        <= serial;
            sync2_reg        <= sync1_reg;
            line_prev_reg    <= sync2_reg;
            pronto_reg       <= 1'b0;
            erro_frame_reg   <= 1'b0;
            erro_timeout_reg <= 1'b0;
`ifdef SERIAL_PARITY_EN
            erro_paridade_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    sample_cnt_reg <= '0;
                    // A start edge takes priority over an expiring timeout.
                    if (start_edge) begin
                        state_reg       <= START;
                        bit_cnt_reg     <= '0;
                        timeout_cnt_reg <= '0;
                    end else if (contagem_reg != 2'd0) begin
                        if (timeout_cnt_reg == TIMEOUT_LAST) begin
                            erro_timeout_reg <= 1'b1;
                            contagem_reg     <= '0;
                            timeout_cnt_reg  <= '0;
                        end else begin
                            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                        end
                    end else begin
                        timeout_cnt_reg <= '0;
                    end
                end
                START: begin
                    if (sample_cnt_reg == HALF_LAST) begin
                        sample_cnt_reg <= '0;
                        state_reg      <= sync2_reg ? IDLE : DATA;
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        sample_cnt_reg <= '0;
                        shift_reg      <= {sync2_reg, shift_reg[6:1]};
                        bit_cnt_reg    <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd6) begin
`ifdef SERIAL_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    end
                end
`ifdef SERIAL_PARITY_EN
                PARITY: begin
                    if (sample_tick) begin
                        sample_cnt_reg <= '0;
                        parity_ok_reg  <= ^{sync2_reg, shift_reg};
                        state_reg      <= STOP;
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sample_tick) begin
                        sample_cnt_reg <= '0;
                        if (!sync2_reg) begin
                            erro_frame_reg <= 1'b1;
                            contagem_reg   <= '0;
                            state_reg      <= WAIT_IDLE;
                        end else if (!parity_good) begin
`ifdef SERIAL_PARITY_EN
                            erro_paridade_reg <= 1'b1;
`endif
                            contagem_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            asm_reg   <= asm_next;
                            state_reg <= IDLE;
                            if (contagem_reg == 2'd3) begin
                                palavra_reg  <= asm_next;
                                pronto_reg   <= 1'b1;
                                contagem_reg <= '0;
                            end else begin
                                contagem_reg <= contagem_reg + 1'b1;
                            end
                        end
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    sample_cnt_reg <= '0;
                    if (sync2_reg) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign palavra      = palavra_reg;
    assign pronto       = pronto_reg;
    assign erro_frame   = erro_frame_reg;
    assign erro_timeout = erro_timeout_reg;
    assign contagem     = contagem_reg;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: expected pulses queued as frames are sent,
// observed pulses queued per clock, and the two queues compared per scenario.
module tb_serial_word_receiver;
    localparam int CPB = 16;
    localparam int TOB = 40;
    localparam logic [27:0] WORD = 28'h86918A3;
    localparam int K_PRONTO = 1, K_PAR = 2, K_FRAME = 3, K_TIMEOUT = 4, K_MULTI = 9;

    typedef struct {
        int          kind;
        logic [27:0] word;
        int          cyc;
    } evt_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        serial = 1'b1;
    logic [27:0] palavra;
    logic        pronto, erro_paridade, erro_frame, erro_timeout;
    logic [1:0]  contagem;

    evt_t        exp_q[$];
    evt_t        obs_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [27:0] exp_word = '0;
    logic [6:0]  chars [4] = '{7'h43, 7'h24, 7'h31, 7'h23};

    serial_word_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clock(clock), .reset(reset), .serial(serial), .palavra(palavra),
        .pronto(pronto), .erro_paridade(erro_paridade), .erro_frame(erro_frame),
        .erro_timeout(erro_timeout), .contagem(contagem)
    );

    always #5 clock = ~clock;

    task automatic tick();
        evt_t o;
        int n;
        @(posedge clock);
        #1;
        cyc++;
        n = int'(pronto) + int'(erro_paridade) + int'(erro_frame) + int'(erro_timeout);
        if (n != 0) begin
            o.kind = (n > 1) ? K_MULTI : pronto ? K_PRONTO : erro_paridade ? K_PAR
                   : erro_frame ? K_FRAME : K_TIMEOUT;
            o.word = palavra;
            o.cyc  = cyc;
            obs_q.push_back(o);
            $display("cycle %0d: pulse kind=%0d palavra=%h", cyc, o.kind, palavra);
        end
    endtask

    task automatic push_exp(input int kind, input logic [27:0] word);
        evt_t e;
        e.kind = kind;
        e.word = word;
        e.cyc  = 0;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        serial = b;
        repeat (CPB) tick();
    endtask

    task automatic send_char(input logic [6:0] c, input int stop_low);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(c[i]);
`ifdef SERIAL_PARITY_EN
        send_bit(~^c);
`endif
        repeat (stop_low) send_bit(1'b0);
        send_bit(1'b1);
        $display("cycle %0d: sent char %h contagem=%0d", cyc, c, contagem);
    endtask

    task automatic send_word();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                push_exp(K_PRONTO, WORD);
                exp_word = WORD;
            end
            send_char(chars[k], 0);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        serial = 1'b1;
        repeat (3) tick();
        checks++;
        if ({palavra, pronto, erro_paridade, erro_frame, erro_timeout, contagem} !== 33'd0) begin
            failures++;
            $display("FAIL reset_outputs: actual palavra=%h contagem=%0d pulses=%b required all 0",
                     palavra, contagem, {pronto, erro_paridade, erro_frame, erro_timeout});
        end
        reset = 1'b1;
        repeat (2 * CPB) tick();
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_quiet: actual %0d pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_basic_word();
        evt_t e, o;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                push_exp(K_PRONTO, WORD);
                exp_word = WORD;
            end
            send_char(chars[k], 0);
            checks++;
            if (contagem !== 2'((k + 1) % 4)) begin
                failures++;
                $display("FAIL word_contagem%0d: actual %0d required %0d", k, contagem, (k + 1) % 4);
            end
        end
        checks++;
        if (palavra !== WORD) begin
            failures++;
            $display("FAIL word_palavra: actual %h required %h", palavra, WORD);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL word_event: actual none required kind=%0d word=%h", e.kind, e.word);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.word !== e.word) begin
                    failures++;
                    $display("FAIL word_event: actual kind=%0d word=%h required kind=%0d word=%h",
                             o.kind, o.word, e.kind, e.word);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL word_extra: actual %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_parity_error();
`ifdef SERIAL_PARITY_EN
        evt_t e, o;
        push_exp(K_PAR, exp_word);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(chars[0][i]);
        send_bit(^chars[0]);
        send_bit(1'b1);
        checks++;
        if (contagem !== 2'd0) begin
            failures++;
            $display("FAIL parity_contagem: actual %0d required 0", contagem);
        end
        send_word();
        checks++;
        if (palavra !== WORD) begin
            failures++;
            $display("FAIL parity_palavra: actual %h required %h", palavra, WORD);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL parity_event: actual none required kind=%0d word=%h", e.kind, e.word);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.word !== e.word) begin
                    failures++;
                    $display("FAIL parity_event: actual kind=%0d word=%h required kind=%0d word=%h",
                             o.kind, o.word, e.kind, e.word);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL parity_extra: actual %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
`endif
    endtask

    task automatic test_frame_error();
        evt_t e, o;
        send_char(chars[0], 0);
        checks++;
        if (contagem !== 2'd1) begin
            failures++;
            $display("FAIL frame_pre_contagem: actual %0d required 1", contagem);
        end
        push_exp(K_FRAME, exp_word);
        send_char(chars[3], 2);
        repeat (CPB) tick();
        checks++;
        if (contagem !== 2'd0 || palavra !== exp_word) begin
            failures++;
            $display("FAIL frame_state: actual contagem=%0d palavra=%h required 0 %h",
                     contagem, palavra, exp_word);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL frame_event: actual none required kind=%0d word=%h", e.kind, e.word);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.word !== e.word) begin
                    failures++;
                    $display("FAIL frame_event: actual kind=%0d word=%h required kind=%0d word=%h",
                             o.kind, o.word, e.kind, e.word);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL frame_extra: actual %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_timeout();
        evt_t e, o;
        int t0;
        send_char(chars[0], 0);
        send_char(chars[1], 0);
        checks++;
        if (contagem !== 2'd2) begin
            failures++;
            $display("FAIL timeout_pre_contagem: actual %0d required 2", contagem);
        end
        t0 = cyc;
        push_exp(K_TIMEOUT, exp_word);
        repeat (TOB + 1) send_bit(1'b1);
        checks++;
        if (contagem !== 2'd0 || palavra !== exp_word) begin
            failures++;
            $display("FAIL timeout_state: actual contagem=%0d palavra=%h required 0 %h",
                     contagem, palavra, exp_word);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL timeout_event: actual none required kind=%0d word=%h", e.kind, e.word);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.word !== e.word) begin
                    failures++;
                    $display("FAIL timeout_event: actual kind=%0d word=%h required kind=%0d word=%h",
                             o.kind, o.word, e.kind, e.word);
                end
                checks++;
                if (o.cyc - t0 < (TOB - 1) * CPB || o.cyc - t0 > TOB * CPB) begin
                    failures++;
                    $display("FAIL timeout_time: actual %0d cycles after char required %0d..%0d",
                             o.cyc - t0, (TOB - 1) * CPB, TOB * CPB);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_extra: actual %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        evt_t e, o;
        send_char(chars[0], 0);
        serial = 1'b0;
        repeat (CPB / 4) tick();
        serial = 1'b1;
        repeat (2 * CPB) tick();
        checks++;
        if (contagem !== 2'd1 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_reject: actual contagem=%0d pulses=%0d required 1 0",
                     contagem, obs_q.size());
            obs_q.delete();
        end
        push_exp(K_PRONTO, WORD);
        exp_word = WORD;
        for (int k = 1; k < 4; k++) send_char(chars[k], 0);
        checks++;
        if (palavra !== WORD || contagem !== 2'd0) begin
            failures++;
            $display("FAIL glitch_word: actual palavra=%h contagem=%0d required %h 0",
                     palavra, contagem, WORD);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL glitch_event: actual none required kind=%0d word=%h", e.kind, e.word);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.word !== e.word) begin
                    failures++;
                    $display("FAIL glitch_event: actual kind=%0d word=%h required kind=%0d word=%h",
                             o.kind, o.word, e.kind, e.word);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_extra: actual %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        evt_t e, o;
        send_char(chars[0], 0);
        send_char(chars[1], 0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(chars[2][i]);
        reset  = 1'b0;
        serial = 1'b1;
        repeat (4) tick();
        exp_word = '0;
        checks++;
        if ({palavra, pronto, erro_paridade, erro_frame, erro_timeout, contagem} !== 33'd0) begin
            failures++;
            $display("FAIL midreset_outputs: actual palavra=%h contagem=%0d pulses=%b required all 0",
                     palavra, contagem, {pronto, erro_paridade, erro_frame, erro_timeout});
        end
        reset = 1'b1;
        repeat (2 * CPB) tick();
        send_word();
        checks++;
        if (palavra !== WORD || contagem !== 2'd0) begin
            failures++;
            $display("FAIL midreset_word: actual palavra=%h contagem=%0d required %h 0",
                     palavra, contagem, WORD);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL midreset_event: actual none required kind=%0d word=%h", e.kind, e.word);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.word !== e.word) begin
                    failures++;
                    $display("FAIL midreset_event: actual kind=%0d word=%h required kind=%0d word=%h",
                             o.kind, o.word, e.kind, e.word);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_extra: actual %0d extra pulses required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_parity_error();
        test_frame_error();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Receives the ASCII serial stream produced by `play_analyser` and reassembles each four-character play into a 28-bit word. Sits directly downstream of the play analyser's `serial` output, on the same 50 MHz clock. The recovered word feeds display and logging logic. It can also be looped back against `resposta` for self-check.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (115200 baud at 50 MHz).
- `TIMEOUT_BITS`, 40: idle bit periods allowed between characters of one word before the partial word is discarded.

Ports:
- `clock`, in, 1: system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `serial`, in, 1: UART line, idle high.
- `palavra`, out, 28: last complete word; first character in [27:21], last in [6:0].
- `pronto`, out, 1: one-cycle pulse when `palavra` is updated.
- `erro_paridade`, out, 1: one-cycle pulse on parity error.
- `erro_frame`, out, 1: one-cycle pulse on bad stop bit.
- `erro_timeout`, out, 1: one-cycle pulse when a partial word expires.
- `contagem`, out, 2: characters accepted so far in the current word (0–3).

## Operation
- Frame format is 1 start bit (0), 7 data bits LSB first, 1 odd-parity bit (see Configuration), then 1 stop bit (1).
- `serial` passes through a 2-flop synchronizer before any use.
- State machine states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: a synchronized falling edge goes to START, with the bit counter cleared.
  - START: the line is sampled at `CLKS_PER_BIT/2`. Low goes to DATA. High is a false start and returns to IDLE, with no error flagged.
  - DATA: each bit is sampled `CLKS_PER_BIT` cycles after the previous sample and shifted in LSB first. After 7 bits, go to PARITY.
  - PARITY: sample and check odd parity over the 7 data bits plus the parity bit. Then go to STOP.
  - STOP: sample the stop bit.
    - High with parity OK: the character is accepted into the assembly register at slot `contagem`, and `contagem` increments. Go to IDLE.
    - Low: pulse `erro_frame` and go to WAIT_IDLE.
    - Parity failed (stop high): pulse `erro_paridade` and go to IDLE.
  - WAIT_IDLE: stay until the synchronized line is high, then go to IDLE.
- Word assembly:
  - An accepted character at `contagem`=k is written to bits [27-7k : 21-7k].
  - When the 4th character is accepted, the full word is copied to `palavra`, `pronto` pulses, and `contagem` returns to 0.
- Any parity or frame error discards the partial word: `contagem` goes to 0. `palavra` is unchanged.
- Timeout:
  - While in IDLE with `contagem`≠0, a counter runs.
  - On reaching `TIMEOUT_BITS*CLKS_PER_BIT` cycles, pulse `erro_timeout` and clear `contagem` to 0.
  - The counter clears on every start edge.
- `pronto` and the three error pulses are mutually exclusive in any given cycle.

## Timing
- Reset values: `palavra`=0, `pronto`=0, all `erro_*`=0, `contagem`=0, FSM in IDLE, assembly register 0.
- Reset asserted mid-frame aborts immediately. After release, the receiver waits for a fresh falling edge.
- Synchronizer latency is 2 cycles from the pin to the FSM.
- Each sample point lands at the mid-bit: `CLKS_PER_BIT/2` after the detected edge, then every `CLKS_PER_BIT` cycles.
- Character length:
  - With parity: 10 bit periods = 4340 cycles.
  - Without parity: 9 bit periods.
- Outputs `pronto`, `erro_*`, `palavra` and `contagem` update on the clock edge after the STOP mid-bit sample.
- `palavra` stays stable until the next `pronto`.
- Back-to-back characters are supported: the next start edge is accepted from the cycle after the STOP sample.
- A start edge and the timeout expiring in the same cycle: the start edge wins, and no timeout is flagged.
- Sample counter width is `$clog2(CLKS_PER_BIT)`+1. Timeout counter width is `$clog2(TIMEOUT_BITS*CLKS_PER_BIT)`+1.

## Configuration
- `SERIAL_PARITY_EN`:
  - Defined: frames carry an odd-parity bit. PARITY state is active and `erro_paridade` is live. This must match the play analyser's transmitter.
  - Undefined: 7N1 frames. PARITY state is removed, STOP follows the 7th data bit, and `erro_paridade` is tied to 0.

## Test plan
- Reset, then send 'C','$','1','#' back-to-back → exactly one `pronto` pulse, `palavra`=0x86918A3, `contagem`=0 afterwards, no error pulses.
- Send 'C' with its parity bit inverted, then the full word 'C','$','1','#' → one `erro_paridade` pulse, no `pronto` after the bad 'C', final `palavra`=0x86918A3.
- Send '#' with stop bit forced low for 2 bit periods → `erro_frame` pulses once, the FSM holds in WAIT_IDLE until the line is high, `contagem`=0.
- Send 'C','$', then hold the line idle for 41 bit periods → `erro_timeout` pulses once at 40 bit periods, `contagem` goes 2→0, `palavra` unchanged.
- Pull the line low for `CLKS_PER_BIT/4` cycles (glitch) → false start is rejected, no pulses, `contagem` unchanged.
- Assert `reset` low midway through the 3rd character → all outputs return to 0; the following full word 'C','$','1','#' then yields `palavra`=0x86918A3.
